tpp_role_sched: RTL and testbench

Role scheduler for the triple ping-pong (TPP) polyvec store behind `preprocess_top`. It assigns each of the three polyvecs one role: FILL (VPU/DP1 writes), PROC (INTT), or DRAIN (mux readout). It rotates the roles when all three stages have finished, and issues the INTT start pulse and the drain request for the buffers that hold data. Downstream bank steering (for example, gating `tppWrEnPacked`) uses its select outputs.

---
 rtl/tpp_pkg.sv | 16 +
 rtl/tpp_role_decode.sv | 23 ++
 rtl/tpp_role_sched.sv | 164 ++++++++++++++++
 tb/tb_tpp_role_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tpp_pkg.sv
// Shared definitions for the triple ping-pong polyvec store: geometry
// constants, the polyvec index type and the mod-3 rotation helper.
package tpp_pkg;

    localparam int NUM_PV   = 3;
    localparam int PV_BANKS = 8;
    localparam int PV_AW    = 9;
    localparam int PV_DW    = 35;

    typedef logic [1:0] pv_idx_t;

    function automatic pv_idx_t pv_next(input pv_idx_t idx);
        return (idx == pv_idx_t'(NUM_PV - 1)) ? pv_idx_t'(0) : pv_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/tpp_role_decode.sv
// Decodes the rotation pointer into the FILL/PROC/DRAIN polyvec selects
// and the one-hot FILL write-enable mask.
module tpp_role_decode
    import tpp_pkg::*;
(
    input  pv_idx_t    p_i,
    output pv_idx_t    fill_sel_o,
    output pv_idx_t    proc_sel_o,
    output pv_idx_t    drain_sel_o,
    output logic [2:0] fill_mask_o
);

    pv_idx_t drain_idx;

    always_comb begin
        drain_idx   = pv_next(p_i);
        fill_sel_o  = p_i;
        drain_sel_o = drain_idx;
        proc_sel_o  = pv_next(drain_idx);
        fill_mask_o = 3'b001 << p_i;
    end

endmodule

// File: rtl/tpp_role_sched.sv
// Role scheduler for the TPP polyvec store: tracks stage completion, rotates
// FILL/PROC/DRAIN and issues INTT start / drain request. Optional INTT
// watchdog is enabled with the TPP_SCHED_TIMEOUT_EN macro.
module tpp_role_sched
    import tpp_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TO_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_i_run,
    input  logic             io_i_fill_done,
    input  logic             io_i_flush,
    input  logic             io_i_intt_done,
    input  logic             io_i_mux_done,
`ifdef TPP_SCHED_TIMEOUT_EN
    input  logic [TO_W-1:0]  io_i_to_limit,
    output logic             io_o_timeout,
`endif
    output logic [1:0]       io_o_fill_sel,
    output logic [1:0]       io_o_proc_sel,
    output logic [1:0]       io_o_drain_sel,
    output logic [2:0]       io_o_fill_mask,
    output logic             io_o_intt_start,
    output logic             io_o_drain_req,
    output logic             io_o_switch,
    output logic [CNT_W-1:0] io_o_switch_cnt,
    output logic             io_o_proto_err
);

    generate
        if (CNT_W < 1 || TO_W < 1) begin : g_bad_param
            $error("tpp_role_sched: CNT_W and TO_W must be at least 1");
        end
    endgenerate

    pv_idx_t          p_q, p_d;
    logic             v_proc_q, v_proc_d;
    logic             v_drain_q, v_drain_d;
    logic             f_done_q, f_done_d;
    logic             f_data_q, f_data_d;
    logic             i_done_q, i_done_d;
    logic             m_done_q, m_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             switch_q, switch_d;
    logic             start_q, start_d;
    logic             err_q, err_d;

    logic fill_evt, fill_err, intt_err, mux_err, swc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            v_proc_q  <= 1'b0;
            v_drain_q <= 1'b0;
            f_done_q  <= 1'b0;
            f_data_q  <= 1'b0;
            i_done_q  <= 1'b0;
            m_done_q  <= 1'b0;
            cnt_q     <= '0;
            switch_q  <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_q       <= p_d;
            v_proc_q  <= v_proc_d;
            v_drain_q <= v_drain_d;
            f_done_q  <= f_done_d;
            f_data_q  <= f_data_d;
            i_done_q  <= i_done_d;
            m_done_q  <= m_done_d;
            cnt_q     <= cnt_d;
            switch_q  <= switch_d;
            start_q   <= start_d;
            err_q     <= err_d;
        end
    end

    // A pulse landing in the switch cycle always hits an already-set flag
    // (or an invalid stage), so it is reported and dropped with no extra case.
    always_comb begin
        fill_evt = io_i_fill_done | io_i_flush;
        fill_err = fill_evt & f_done_q;
        intt_err = io_i_intt_done & (!v_proc_q | i_done_q);
        mux_err  = io_i_mux_done & (!v_drain_q | m_done_q);
        swc      = io_i_run & f_done_q & (i_done_q | !v_proc_q) & (m_done_q | !v_drain_q);

        p_d       = p_q;
        v_proc_d  = v_proc_q;
        v_drain_d = v_drain_q;
        f_done_d  = f_done_q;
        f_data_d  = f_data_q;
        i_done_d  = i_done_q;
        m_done_d  = m_done_q;
        cnt_d     = cnt_q;
        switch_d  = 1'b0;
        start_d   = 1'b0;
        err_d     = err_q | fill_err | intt_err | mux_err;

        if (swc) begin
            p_d       = pv_next(p_q);
            v_drain_d = v_proc_q;
            v_proc_d  = f_data_q;
            f_done_d  = 1'b0;
            f_data_d  = 1'b0;
            i_done_d  = 1'b0;
            m_done_d  = 1'b0;
            cnt_d     = cnt_q + CNT_W'(1);
            switch_d  = 1'b1;
            start_d   = f_data_q;
        end else begin
            if (fill_evt && !fill_err) begin
                f_done_d = 1'b1;
                f_data_d = io_i_fill_done;
            end
            if (io_i_intt_done && !intt_err) i_done_d = 1'b1;
            if (io_i_mux_done && !mux_err)   m_done_d = 1'b1;
        end
    end

`ifdef TPP_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;
    logic            timeout_q, timeout_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            timeout_q <= timeout_d;
        end
    end

    // Compare the next count so the flag rises in the cycle the count reaches the limit.
    always_comb begin
        to_d = to_q;
        if (swc) begin
            to_d = '0;
        end else if (v_proc_q && !i_done_q && to_q != io_i_to_limit) begin
            to_d = to_q + TO_W'(1);
        end
        timeout_d = timeout_q | ((io_i_to_limit != '0) && (to_d == io_i_to_limit));
    end

    assign io_o_timeout = timeout_q;
`endif

    tpp_role_decode u_decode (
        .p_i         (p_q),
        .fill_sel_o  (io_o_fill_sel),
        .proc_sel_o  (io_o_proc_sel),
        .drain_sel_o (io_o_drain_sel),
        .fill_mask_o (io_o_fill_mask)
    );

    assign io_o_intt_start = start_q;
    assign io_o_drain_req  = v_drain_q & !m_done_q;
    assign io_o_switch     = switch_q;
    assign io_o_switch_cnt = cnt_q;
    assign io_o_proto_err  = err_q;

endmodule

// File: tb/tb_tpp_role_sched.sv
// Directed bench for tpp_role_sched: rotation, start/drain handshake,
// protocol errors, run gating and (with TPP_SCHED_TIMEOUT_EN) the watchdog.
module tb_tpp_role_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0, fill_done = 1'b0, flush = 1'b0, intt_done = 1'b0, mux_done = 1'b0;
    logic [1:0]  fill_sel, proc_sel, drain_sel;
    logic [2:0]  fill_mask;
    logic        intt_start, drain_req, sw, perr;
    logic [15:0] sw_cnt;
`ifdef TPP_SCHED_TIMEOUT_EN
    logic [15:0] to_limit = 16'd0;
    logic        timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    tpp_role_sched #(.CNT_W(16), .TO_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_i_run        (run),
        .io_i_fill_done  (fill_done),
        .io_i_flush      (flush),
        .io_i_intt_done  (intt_done),
        .io_i_mux_done   (mux_done),
`ifdef TPP_SCHED_TIMEOUT_EN
        .io_i_to_limit   (to_limit),
        .io_o_timeout    (timeout),
`endif
        .io_o_fill_sel   (fill_sel),
        .io_o_proc_sel   (proc_sel),
        .io_o_drain_sel  (drain_sel),
        .io_o_fill_mask  (fill_mask),
        .io_o_intt_start (intt_start),
        .io_o_drain_req  (drain_req),
        .io_o_switch     (sw),
        .io_o_switch_cnt (sw_cnt),
        .io_o_proto_err  (perr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic f, input logic fl, input logic it, input logic mx);
        fill_done = f; flush = fl; intt_done = it; mux_done = mx;
        tick();
        fill_done = 1'b0; flush = 1'b0; intt_done = 1'b0; mux_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (fill_sel !== 2'd0) begin n_bad++; $display("FAIL rst_fill got %0d want 0", fill_sel); end
        n_cmp++; if (drain_sel !== 2'd1) begin n_bad++; $display("FAIL rst_drain got %0d want 1", drain_sel); end
        n_cmp++; if (proc_sel !== 2'd2) begin n_bad++; $display("FAIL rst_proc got %0d want 2", proc_sel); end
        n_cmp++; if (fill_mask !== 3'b001) begin n_bad++; $display("FAIL rst_mask got %b want 001", fill_mask); end
        n_cmp++; if ({intt_start, drain_req, sw, perr} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {intt_start, drain_req, sw, perr}); end
        n_cmp++; if (sw_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", sw_cnt); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_first_switch();
        run = 1'b1;
        tick(); tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (sw !== 1'b0) begin n_bad++; $display("FAIL sw1_early got %b want 0", sw); end
        tick();
        n_cmp++; if (sw !== 1'b1) begin n_bad++; $display("FAIL sw1_pulse got %b want 1", sw); end
        n_cmp++; if ({fill_sel, proc_sel, drain_sel} !== {2'd1, 2'd0, 2'd2}) begin n_bad++; $display("FAIL sw1_roles got %0d/%0d/%0d want 1/0/2", fill_sel, proc_sel, drain_sel); end
        n_cmp++; if (fill_mask !== 3'b010) begin n_bad++; $display("FAIL sw1_mask got %b want 010", fill_mask); end
        n_cmp++; if (intt_start !== 1'b1) begin n_bad++; $display("FAIL sw1_start got %b want 1", intt_start); end
        n_cmp++; if (drain_req !== 1'b0) begin n_bad++; $display("FAIL sw1_dreq got %b want 0", drain_req); end
        n_cmp++; if (sw_cnt !== 16'd1) begin n_bad++; $display("FAIL sw1_cnt got %0d want 1", sw_cnt); end
        tick();
        n_cmp++; if ({intt_start, sw} !== 2'b00) begin n_bad++; $display("FAIL sw1_oneshot got %b want 00", {intt_start, sw}); end
    endtask

    task automatic test_second_switch();
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        n_cmp++; if ({fill_sel, proc_sel, drain_sel} !== {2'd2, 2'd1, 2'd0}) begin n_bad++; $display("FAIL sw2_roles got %0d/%0d/%0d want 2/1/0", fill_sel, proc_sel, drain_sel); end
        n_cmp++; if ({sw, intt_start, drain_req} !== 3'b111) begin n_bad++; $display("FAIL sw2_outs got %b want 111", {sw, intt_start, drain_req}); end
        n_cmp++; if (sw_cnt !== 16'd2) begin n_bad++; $display("FAIL sw2_cnt got %0d want 2", sw_cnt); end
        tick();
        n_cmp++; if (drain_req !== 1'b1) begin n_bad++; $display("FAIL sw2_dreq_hold got %b want 1", drain_req); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (drain_req !== 1'b0) begin n_bad++; $display("FAIL sw2_dreq_drop got %b want 0", drain_req); end
        n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL sw2_perr got %b want 0", perr); end
    endtask

    task automatic test_flush();
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        n_cmp++; if ({sw, intt_start} !== 2'b10) begin n_bad++; $display("FAIL fl1_pulses got %b want 10", {sw, intt_start}); end
        n_cmp++; if (fill_sel !== 2'd0) begin n_bad++; $display("FAIL fl1_fill got %0d want 0", fill_sel); end
        n_cmp++; if (drain_req !== 1'b1) begin n_bad++; $display("FAIL fl1_dreq got %b want 1", drain_req); end
        n_cmp++; if (sw_cnt !== 16'd3) begin n_bad++; $display("FAIL fl1_cnt got %0d want 3", sw_cnt); end
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        n_cmp++; if ({sw, intt_start, drain_req} !== 3'b100) begin n_bad++; $display("FAIL fl2_outs got %b want 100", {sw, intt_start, drain_req}); end
        n_cmp++; if (fill_sel !== 2'd1) begin n_bad++; $display("FAIL fl2_fill got %0d want 1", fill_sel); end
        tick();
        n_cmp++; if ({sw, drain_req, perr} !== 3'b000) begin n_bad++; $display("FAIL fl2_after got %b want 000", {sw, drain_req, perr}); end
    endtask

    task automatic test_proto_err();
        run = 1'b0;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL pe_intt got %b want 1", perr); end
        n_cmp++; if ({fill_sel, sw} !== {2'd1, 1'b0}) begin n_bad++; $display("FAIL pe_roles got %0d/%b want 1/0", fill_sel, sw); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({perr, fill_sel, sw_cnt} !== {1'b0, 2'd0, 16'd0}) begin n_bad++; $display("FAIL pe_async_rst got %b/%0d/%0d want 0/0/0", perr, fill_sel, sw_cnt); end
        tick();
        n_cmp++; if (intt_start !== 1'b0) begin n_bad++; $display("FAIL pe_rst_start got %b want 0", intt_start); end
        reset = 1'b0;
        tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL pe_first_fill got %b want 0", perr); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL pe_dup_fill got %b want 1", perr); end
        n_cmp++; if ({fill_sel, sw, sw_cnt} !== {2'd0, 1'b0, 16'd0}) begin n_bad++; $display("FAIL pe_hold got %0d/%b/%0d want 0/0/0", fill_sel, sw, sw_cnt); end
    endtask

    task automatic test_run_gate();
        tick(); tick();
        n_cmp++; if ({sw, fill_sel} !== {1'b0, 2'd0}) begin n_bad++; $display("FAIL rg_hold got %b/%0d want 0/0", sw, fill_sel); end
        run = 1'b1;
        tick();
        n_cmp++; if ({sw, intt_start, fill_sel} !== {1'b1, 1'b1, 2'd1}) begin n_bad++; $display("FAIL rg_switch got %b/%b/%0d want 1/1/1", sw, intt_start, fill_sel); end
        n_cmp++; if (sw_cnt !== 16'd1) begin n_bad++; $display("FAIL rg_cnt got %0d want 1", sw_cnt); end
    endtask

    task automatic test_back_to_back();
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (sw !== 1'b0) begin n_bad++; $display("FAIL bb_gap got %b want 0", sw); end
        tick();
        n_cmp++; if ({sw, intt_start, drain_req} !== 3'b111) begin n_bad++; $display("FAIL bb_outs got %b want 111", {sw, intt_start, drain_req}); end
        n_cmp++; if ({fill_sel, proc_sel, drain_sel, sw_cnt} !== {2'd2, 2'd1, 2'd0, 16'd2}) begin n_bad++; $display("FAIL bb_roles got %0d/%0d/%0d/%0d want 2/1/0/2", fill_sel, proc_sel, drain_sel, sw_cnt); end
    endtask

`ifdef TPP_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        to_limit = 16'd10;
        run = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (intt_start !== 1'b1) begin n_bad++; $display("FAIL to_start got %b want 1", intt_start); end
        repeat (9) tick();
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_early got %b want 0", timeout); end
        tick();
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_fire got %b want 1", timeout); end
        n_cmp++; if ({fill_sel, sw_cnt} !== {2'd1, 16'd1}) begin n_bad++; $display("FAIL to_roles got %0d/%0d want 1/1", fill_sel, sw_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_switch();
        test_second_switch();
        test_flush();
        test_proto_err();
        test_run_gate();
        test_back_to_back();
`ifdef TPP_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
